// File: rtl/rob_superscalar.sv
// Reorder buffer: single-wide dispatch, multi-port write-back, in-order
// multi-slot commit, operand lookups and flush on jump / taken branch.
module rob_superscalar #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TAG_W    = $clog2(DEPTH),
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WB_PORTS = 5,
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_valid,
  input  logic [4:0]                   alloc_rd,
  input  logic [1:0]                   alloc_kind,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_next_pc,
  input  logic [WB_PORTS-1:0]          wb_taken,
  input  logic [2*TAG_W-1:0]           qry_tag,
  output logic [1:0]                   qry_ready,
  output logic [2*DATA_W-1:0]          qry_data,
  output logic [COMMIT_W-1:0]          cm_valid,
  output logic [COMMIT_W-1:0]          cm_we,
  output logic [COMMIT_W*5-1:0]        cm_rd,
  output logic [COMMIT_W*DATA_W-1:0]   cm_data,
  output logic [COMMIT_W*TAG_W-1:0]    cm_tag,
  output logic                         redirect_valid,
  output logic [DATA_W-1:0]            redirect_pc,
  output logic [TAG_W-1:0]             head_tag,
  output logic                         head_valid,
  output logic [TAG_W:0]               count,
  output logic                         empty
);

  localparam int unsigned CNT_W = TAG_W + 1;
  localparam logic [1:0] K_COMMON = 2'd0;
  localparam logic [1:0] K_JUMP   = 2'd2;
  localparam logic [1:0] K_BRANCH = 2'd3;

  logic [DEPTH-1:0]  e_valid;
  logic [DEPTH-1:0]  e_ready;
  logic [DEPTH-1:0]  e_taken;
  logic [1:0]        e_kind [DEPTH];
  logic [4:0]        e_rd   [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];
  logic [DATA_W-1:0] e_npc  [DEPTH];

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;

  logic [TAG_W-1:0]  slot_idx [COMMIT_W];
  logic [COMMIT_W-1:0] ret_c;
  logic [CNT_W-1:0]  n_ret_c;
  logic              stop_c;
  logic              flush_c;
  logic [DATA_W-1:0] flush_pc_c;
  logic              alloc_fire_c;

  assign alloc_ready  = (cnt < CNT_W'(DEPTH));
  assign alloc_fire_c = alloc_valid && alloc_ready;
  assign alloc_tag    = tail;
  assign head_tag     = head;
  assign head_valid   = e_valid[head];
  assign count        = cnt;
  assign empty        = (cnt == '0);

  // In-order commit scan; a flushing entry ends the group, a not-taken branch does not
  always_comb begin
    ret_c      = '0;
    n_ret_c    = '0;
    stop_c     = 1'b0;
    flush_c    = 1'b0;
    flush_pc_c = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      slot_idx[i] = head + TAG_W'(i);
      if (!stop_c && e_valid[slot_idx[i]] && e_ready[slot_idx[i]]) begin
        ret_c[i] = 1'b1;
        n_ret_c  = n_ret_c + CNT_W'(1);
        if (e_kind[slot_idx[i]] == K_JUMP ||
            (e_kind[slot_idx[i]] == K_BRANCH && e_taken[slot_idx[i]])) begin
          stop_c     = 1'b1;
          flush_c    = 1'b1;
          flush_pc_c = e_npc[slot_idx[i]];
        end
      end else begin
        stop_c = 1'b1;
      end
    end
  end

  // Operand lookups straight from registered entry state
  always_comb begin
    qry_ready = '0;
    qry_data  = '0;
    for (int q = 0; q < 2; q++) begin
      qry_ready[q] = e_valid[qry_tag[q*TAG_W +: TAG_W]] & e_ready[qry_tag[q*TAG_W +: TAG_W]];
      qry_data[q*DATA_W +: DATA_W] = e_data[qry_tag[q*TAG_W +: TAG_W]];
    end
  end

  // Entry storage: write-back (highest port last), retire, then flush or allocate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= '0;
      e_ready <= '0;
      e_taken <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        e_kind[e] <= K_COMMON;
        e_rd[e]   <= '0;
        e_data[e] <= '0;
        e_npc[e]  <= '0;
      end
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && e_valid[wb_tag[p*TAG_W +: TAG_W]]) begin
          e_ready[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
          e_data[wb_tag[p*TAG_W +: TAG_W]]  <= wb_data[p*DATA_W +: DATA_W];
          e_npc[wb_tag[p*TAG_W +: TAG_W]]   <= wb_next_pc[p*DATA_W +: DATA_W];
          e_taken[wb_tag[p*TAG_W +: TAG_W]] <= wb_taken[p];
        end
      end
      for (int i = 0; i < COMMIT_W; i++) begin
        if (ret_c[i]) e_valid[slot_idx[i]] <= 1'b0;
      end
      if (flush_c) begin
        e_valid <= '0;
      end else if (alloc_fire_c) begin
        e_valid[tail] <= 1'b1;
        e_ready[tail] <= 1'b0;
        e_kind[tail]  <= alloc_kind;
        e_rd[tail]    <= alloc_rd;
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush_c) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + n_ret_c[TAG_W-1:0];
      tail <= tail + TAG_W'(alloc_fire_c);
      cnt  <= cnt + CNT_W'(alloc_fire_c) - n_ret_c;
    end
  end

  // Registered commit and redirect pulses, zero when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_valid       <= '0;
      cm_we          <= '0;
      cm_rd          <= '0;
      cm_data        <= '0;
      cm_tag         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      cm_valid       <= ret_c;
      redirect_valid <= flush_c;
      redirect_pc    <= flush_pc_c;
      for (int i = 0; i < COMMIT_W; i++) begin
        cm_we[i]                    <= ret_c[i] &&
                                       (e_kind[slot_idx[i]] == K_COMMON || e_kind[slot_idx[i]] == K_JUMP);
        cm_rd[i*5 +: 5]             <= ret_c[i] ? e_rd[slot_idx[i]] : 5'd0;
        cm_data[i*DATA_W +: DATA_W] <= ret_c[i] ? e_data[slot_idx[i]] : '0;
        cm_tag[i*TAG_W +: TAG_W]    <= ret_c[i] ? slot_idx[i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rob_superscalar.sv
// Directed bench for rob_superscalar: expected commits and redirects are queued
// at write-back time and a negedge monitor pops them as the DUT retires.
module tb_rob_superscalar;

  localparam int unsigned DEPTH = 8, TAG_W = 3, DATA_W = 32, WB_PORTS = 5, COMMIT_W = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       alloc_valid;
  logic [4:0]                 alloc_rd;
  logic [1:0]                 alloc_kind;
  logic                       alloc_ready;
  logic [TAG_W-1:0]           alloc_tag;
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*TAG_W-1:0]  wb_tag;
  logic [WB_PORTS*DATA_W-1:0] wb_data;
  logic [WB_PORTS*DATA_W-1:0] wb_next_pc;
  logic [WB_PORTS-1:0]        wb_taken;
  logic [2*TAG_W-1:0]         qry_tag;
  logic [1:0]                 qry_ready;
  logic [2*DATA_W-1:0]        qry_data;
  logic [COMMIT_W-1:0]        cm_valid;
  logic [COMMIT_W-1:0]        cm_we;
  logic [COMMIT_W*5-1:0]      cm_rd;
  logic [COMMIT_W*DATA_W-1:0] cm_data;
  logic [COMMIT_W*TAG_W-1:0]  cm_tag;
  logic                       redirect_valid;
  logic [DATA_W-1:0]          redirect_pc;
  logic [TAG_W-1:0]           head_tag;
  logic                       head_valid;
  logic [TAG_W:0]             count;
  logic                       empty;

  rob_superscalar #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
                    .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_kind(alloc_kind),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_next_pc(wb_next_pc), .wb_taken(wb_taken),
    .qry_tag(qry_tag), .qry_ready(qry_ready), .qry_data(qry_data),
    .cm_valid(cm_valid), .cm_we(cm_we), .cm_rd(cm_rd), .cm_data(cm_data), .cm_tag(cm_tag),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .head_tag(head_tag), .head_valid(head_valid), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic              we;
  } cm_t;

  cm_t               exp_cm[$];
  logic [DATA_W-1:0] exp_rd[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [1:0] kind);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    alloc_kind  = kind;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                        input logic [DATA_W-1:0] npc, input logic taken);
    wb_valid[p]                    = 1'b1;
    wb_tag[p*TAG_W +: TAG_W]       = tag;
    wb_data[p*DATA_W +: DATA_W]    = data;
    wb_next_pc[p*DATA_W +: DATA_W] = npc;
    wb_taken[p]                    = taken;
  endtask

  task automatic push_cm(input logic [TAG_W-1:0] tag, input logic [4:0] rd,
                         input logic [DATA_W-1:0] data, input logic we);
    cm_t e;
    e.tag = tag; e.rd = rd; e.data = data; e.we = we;
    exp_cm.push_back(e);
  endtask

  // Monitor: every retiring slot and every redirect must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < COMMIT_W; s++) begin
        if (cm_valid[s]) begin
          cm_t act, e;
          act = {cm_tag[s*TAG_W +: TAG_W], cm_rd[s*5 +: 5], cm_data[s*DATA_W +: DATA_W], cm_we[s]};
          n_cmp++;
          if (exp_cm.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_commit slot %0d: got tag %0d rd %0d data %0h", s,
                     act.tag, act.rd, act.data);
          end else begin
            e = exp_cm.pop_front();
            if (act !== e) begin
              n_bad++;
              $display("FAIL commit slot %0d: got tag %0d rd %0d data %0h we %0b expected tag %0d rd %0d data %0h we %0b",
                       s, act.tag, act.rd, act.data, act.we, e.tag, e.rd, e.data, e.we);
            end
          end
        end
      end
      if (redirect_valid) begin
        n_cmp++;
        if (exp_rd.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_redirect: got pc %0h", redirect_pc);
        end else begin
          logic [DATA_W-1:0] pc;
          pc = exp_rd.pop_front();
          if (redirect_pc !== pc) begin
            n_bad++;
            $display("FAIL redirect_pc: got %0h expected %0h", redirect_pc, pc);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_rd = '0; alloc_kind = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_next_pc = '0; wb_taken = '0; qry_tag = '0;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_cm_valid", 64'(cm_valid), 64'd0);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_head", 64'({head_valid, head_tag, alloc_tag}), 64'd0);
    chk("rst_qry", 64'({qry_ready, qry_data}), 64'd0);
    rst_n = 1'b1;
    step();

    // Fill all 8 entries, then a 9th request must be refused
    for (int i = 0; i < 8; i++) begin
      chk("fill_alloc_tag", 64'(alloc_tag), 64'(i));
      alloc(5'(i), 2'd0);
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
    alloc(5'd8, 2'd0);
    chk("over_count", 64'(count), 64'd8);
    chk("wrap_alloc_tag", 64'(alloc_tag), 64'd0);

    for (int i = 0; i < 8; i++) push_cm(3'(i), 5'(i), 32'h100 + 32'(i), 1'b1);
    for (int i = 0; i < 5; i++) set_wb(i, 3'(i), 32'h100 + 32'(i), '0, 1'b0);
    step();
    wb_valid = '0;
    for (int i = 0; i < 3; i++) set_wb(i, 3'(i + 5), 32'h105 + 32'(i), '0, 1'b0);
    step();
    wb_valid = '0;
    step(5);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_empty", 64'(empty), 64'd1);

    // Two heads ready in the same cycle, third pending
    alloc(5'd1, 2'd0); alloc(5'd2, 2'd0); alloc(5'd3, 2'd0);
    set_wb(0, 3'd1, 32'h11, '0, 1'b0);
    set_wb(1, 3'd0, 32'h10, '0, 1'b0);
    push_cm(3'd0, 5'd1, 32'h10, 1'b1);
    push_cm(3'd1, 5'd2, 32'h11, 1'b1);
    step();
    wb_valid = '0;
    step(2);
    chk("pending_count", 64'(count), 64'd1);
    chk("pending_head", 64'({head_valid, head_tag}), 64'({1'b1, 3'd2}));

    // Younger entries ready while head is not: nothing retires
    alloc(5'd4, 2'd0); alloc(5'd5, 2'd0);
    set_wb(0, 3'd4, 32'h44, '0, 1'b0);
    set_wb(1, 3'd3, 32'h33, '0, 1'b0);
    step();
    wb_valid = '0;
    step(3);
    chk("blocked_count", 64'(count), 64'd3);
    set_wb(0, 3'd2, 32'h22, '0, 1'b0);
    push_cm(3'd2, 5'd3, 32'h22, 1'b1);
    push_cm(3'd3, 5'd4, 32'h33, 1'b1);
    push_cm(3'd4, 5'd5, 32'h44, 1'b1);
    step();
    wb_valid = '0;
    step(3);
    chk("inorder_count", 64'(count), 64'd0);

    // Taken branch at tag 5 flushes; ready common behind it and a same-cycle alloc are dropped
    chk("br_alloc_tag", 64'(alloc_tag), 64'd5);
    alloc(5'd0, 2'd3); alloc(5'd7, 2'd0);
    set_wb(0, 3'd5, 32'h55, 32'h40, 1'b1);
    set_wb(1, 3'd6, 32'h66, '0, 1'b0);
    push_cm(3'd5, 5'd0, 32'h55, 1'b0);
    exp_rd.push_back(32'h40);
    step();
    wb_valid = '0;
    alloc(5'd12, 2'd0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_ptrs", 64'({head_valid, head_tag, alloc_tag}), 64'd0);
    step(2);

    // Not-taken branch and common retire together; jump then redirects
    alloc(5'd9, 2'd3); alloc(5'd10, 2'd0); alloc(5'd5, 2'd2);
    set_wb(0, 3'd0, 32'h77, 32'h80, 1'b0);
    set_wb(1, 3'd1, 32'hA1, '0, 1'b0);
    set_wb(2, 3'd2, 32'h1234, 32'h200, 1'b0);
    push_cm(3'd0, 5'd9, 32'h77, 1'b0);
    push_cm(3'd1, 5'd10, 32'hA1, 1'b1);
    push_cm(3'd2, 5'd5, 32'h1234, 1'b1);
    exp_rd.push_back(32'h200);
    step();
    wb_valid = '0;
    step();
    chk("ntb_count", 64'(count), 64'd1);
    step();
    chk("jump_count", 64'(count), 64'd0);

    // Same tag on two ports: highest port wins; write-back to a free tag is dropped
    alloc(5'd3, 2'd0);
    qry_tag = {3'd5, 3'd0};
    chk("qry_not_ready", 64'(qry_ready), 64'd0);
    set_wb(0, 3'd0, 32'hAA, '0, 1'b0);
    set_wb(4, 3'd0, 32'hBB, '0, 1'b0);
    set_wb(2, 3'd5, 32'h99, '0, 1'b0);
    push_cm(3'd0, 5'd3, 32'hBB, 1'b1);
    step();
    wb_valid = '0;
    chk("qry_ready", 64'(qry_ready), 64'b01);
    chk("qry_data0", 64'(qry_data[31:0]), 64'hBB);
    step(2);
    chk("qry_drain", 64'(count), 64'd0);

    // Asynchronous reset mid-stream
    alloc(5'd1, 2'd0); alloc(5'd2, 2'd0); alloc(5'd3, 2'd0);
    chk("pre_rst_count", 64'(count), 64'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_ready", 64'({alloc_ready, empty}), 64'b11);
    #2 rst_n = 1'b1;
    step(2);
    chk("post_rst_count", 64'(count), 64'd0);

    chk("commits_left", 64'(exp_cm.size()), 64'd0);
    chk("redirects_left", 64'(exp_rd.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
